// File: rtl/branch_resolve_if.sv
// Bundle between the issue/ALU side and the branch resolution stage.
// When BRANCH_STATS_EN is defined, the interface also carries the
// branch_count and taken_count statistics outputs.
interface branch_resolve_if;
  logic        valid;
  logic [3:0]  inst_id;
  logic [15:0] pc;
  logic [15:0] offset;
  logic [15:0] alu_out;
  logic        busy;
  logic        redirect;
  logic [15:0] target;
  logic        flush;
`ifdef BRANCH_STATS_EN
  logic [15:0] branch_count;
  logic [15:0] taken_count;

  modport master (
    output valid, inst_id, pc, offset, alu_out,
    input  busy, redirect, target, flush, branch_count, taken_count
  );

  modport slave (
    input  valid, inst_id, pc, offset, alu_out,
    output busy, redirect, target, flush, branch_count, taken_count
  );
`else
  modport master (
    output valid, inst_id, pc, offset, alu_out,
    input  busy, redirect, target, flush
  );

  modport slave (
    input  valid, inst_id, pc, offset, alu_out,
    output busy, redirect, target, flush
  );
`endif
endinterface

// File: rtl/branch_resolve.sv
// Branch resolution stage sitting directly behind the ALU.
// A branch is captured at issue, and its condition is evaluated against the
// registered ALU result one cycle later. A taken branch produces a one-cycle
// redirect with target = pc + offset (modulo 2^16) and a two-cycle flush.
// The ALU's own zero/pos flags lag by a cycle and are sticky, so the
// condition is recomputed from alu_out here.
// Optional feature macro: BRANCH_STATS_EN adds saturating branch_count and
// taken_count outputs.
module branch_resolve (
  input  logic            clock,
  input  logic            reset,
  branch_resolve_if.slave bus
);

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVAL  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               busy_q, busy_d;
  logic               redirect_q, redirect_d;
  logic               flush_q, flush_d;
  logic               cnt_q, cnt_d;
  logic [DATA_W-1:0]  target_q, target_d;

  logic [DATA_W-1:0]  pc_q, pc_d;
  logic [DATA_W-1:0]  offset_q, offset_d;
  logic [1:0]         cond_q, cond_d;

  logic                     is_branch;
  logic                     taken;
  logic signed [DATA_W-1:0] alu_s;

`ifdef BRANCH_STATS_EN
  logic [15:0] branch_count_q, branch_count_d;
  logic [15:0] taken_count_q, taken_count_d;
`endif

  // Condition encoding is the low two opcode bits: 00 beq, 01 bne, 10 bgt, 11 ble.
  function automatic logic cond_taken(input logic [1:0] cond,
                                      input logic signed [DATA_W-1:0] res);
    logic gt;
    gt = (res > 16'sd0);
    case (cond)
      2'b00:   return (res == 16'sd0);
      2'b01:   return (res != 16'sd0);
      2'b10:   return gt;
      default: return !gt;
    endcase
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign is_branch = bus.valid && (bus.inst_id[3:2] == 2'b11);
  assign alu_s     = bus.alu_out;
  assign taken     = cond_taken(cond_q, alu_s);

  // Next-state and next-output logic for the resolve FSM.
  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    redirect_d = 1'b0;
    flush_d    = flush_q;
    cnt_d      = cnt_q;
    target_d   = target_q;
    pc_d       = pc_q;
    offset_d   = offset_q;
    cond_d     = cond_q;
`ifdef BRANCH_STATS_EN
    branch_count_d = branch_count_q;
    taken_count_d  = taken_count_q;
`endif
    case (state_q)
      IDLE: begin
        if (is_branch) begin
          pc_d     = bus.pc;
          offset_d = bus.offset;
          cond_d   = bus.inst_id[1:0];
          state_d  = EVAL;
          busy_d   = 1'b1;
`ifdef BRANCH_STATS_EN
          branch_count_d = sat_inc(branch_count_q);
`endif
        end
      end
      EVAL: begin
        if (taken) begin
          redirect_d = 1'b1;
          target_d   = pc_q + offset_q;
          flush_d    = 1'b1;
          cnt_d      = 1'b1;
          state_d    = FLUSH;
`ifdef BRANCH_STATS_EN
          taken_count_d = sat_inc(taken_count_q);
`endif
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      FLUSH: begin
        if (cnt_q == 1'b0) begin
          state_d = IDLE;
          flush_d = 1'b0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        busy_d   = 1'b0;
        flush_d  = 1'b0;
        cnt_d    = 1'b0;
      end
    endcase
  end

  // Control and output registers; reset drops any pending branch.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      redirect_q <= 1'b0;
      flush_q    <= 1'b0;
      cnt_q      <= 1'b0;
      target_q   <= '0;
`ifdef BRANCH_STATS_EN
      branch_count_q <= '0;
      taken_count_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      redirect_q <= redirect_d;
      flush_q    <= flush_d;
      cnt_q      <= cnt_d;
      target_q   <= target_d;
`ifdef BRANCH_STATS_EN
      branch_count_q <= branch_count_d;
      taken_count_q  <= taken_count_d;
`endif
    end
  end

  // Captured branch operands; only read in EVAL, so no reset needed.
  always_ff @(posedge clock) begin
    pc_q     <= pc_d;
    offset_q <= offset_d;
    cond_q   <= cond_d;
  end

  assign bus.busy     = busy_q;
  assign bus.redirect = redirect_q;
  assign bus.flush    = flush_q;
  assign bus.target   = target_q;
`ifdef BRANCH_STATS_EN
  assign bus.branch_count = branch_count_q;
  assign bus.taken_count  = taken_count_q;
`endif

endmodule

// File: doc/branch_resolve.md
# branch_resolve

Branch resolution stage directly downstream of the ALU. Captures a branch when it issues to the ALU, takes the ALU's registered 16-bit result one cycle later, and decides whether the branch is taken. On a taken branch it raises a one-cycle PC redirect with the computed target, plus a two-cycle pipeline flush. The fetch stage follows a static not-taken policy.

## Interface
Parameters:
- None. Datapath width is fixed at 16 bits.

Ports:
- clock  in  1  single system clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- valid  in  1  an instruction is issued to the ALU this cycle
- inst_id  in  4  opcode of the issued instruction, the same value the ALU receives
- pc  in  16  address of the issued instruction
- offset  in  16  sign-agnostic branch offset; the target is pc + offset
- alu_out  in  16  registered ALU result, valid the cycle after issue
- busy  out  1  a branch is in flight; upstream must not issue while high
- redirect  out  1  one-cycle pulse: the branch is taken
- target  out  16  redirect address; meaningful only while redirect is high
- flush  out  1  kill younger instructions in fetch and decode

## Operation
- Branch opcodes (the ALU subtracts for all four):
  - 4'b1100 beq: taken when alu_out == 0.
  - 4'b1101 bne: taken when alu_out != 0.
  - 4'b1110 bgt: taken when alu_out[15] == 0 and alu_out != 0 (signed > 0).
  - 4'b1111 ble: taken when bgt is false.
- The condition is derived internally from alu_out. The ALU's zero/pos flags are not used, because they lag out by one cycle and are sticky.
- Any other inst_id with valid=1 is ignored.
- State machine, states IDLE, EVAL, FLUSH:
  - IDLE: on valid && branch opcode, latch pc, offset and the 2-bit condition, then go to EVAL.
  - EVAL: evaluate the condition against alu_out.
    - Taken: register redirect=1, target=pc+offset and flush=1, load the flush counter with 1, go to FLUSH.
    - Not taken: go to IDLE with no outputs asserted.
  - FLUSH: redirect=0 and flush=1. Decrement the counter; at 0, go to IDLE and clear flush.
- busy=1 in EVAL and FLUSH. A valid seen while busy is ignored; upstream must hold the instruction.
- Target arithmetic is modulo 2^16. Carry-out is discarded, so 16'hFFF0 + 16'h0020 gives 16'h0010.
- Reset values: state=IDLE, busy=0, redirect=0, flush=0, target=16'h0000, counter=0.
- Reset while in EVAL or FLUSH drops the pending branch. All outputs read reset values in the following cycle, and no redirect fires.

## Timing
- Cycle T: branch issued and latched.
- T+1: EVAL; alu_out is sampled; busy=1.
- T+2, taken: redirect=1, target valid, flush=1.
- T+3: redirect=0, flush=1.
- T+4: IDLE; busy=0, flush=0. A new issue is accepted in T+4.
- Not taken: IDLE at T+2 with busy=0. A new issue is accepted in T+2.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- BRANCH_STATS_EN defined:
  - Adds outputs branch_count[15:0] and taken_count[15:0].
  - branch_count increments once per branch entering EVAL.
  - taken_count increments once per taken branch.
  - Both counters saturate at 16'hFFFF and are cleared by reset.
- Undefined: these ports and counters do not exist. Behaviour is otherwise identical.

## Test plan
- beq taken: issue 4'b1100 with pc=16'h0040, offset=16'h0010; alu_out=0 at T+1.
  - Required: redirect=1 and target=16'h0050 at T+2 only; flush=1 at T+2 and T+3; busy low at T+4.
- bgt sign boundary, two runs:
  - alu_out=16'h8000: not taken; no redirect; busy=0 at T+2.
  - alu_out=16'h0001: taken.
- Wrap and ignore: pc=16'hFFF0, offset=16'h0020, bne with alu_out=16'h0003.
  - Required: target=16'h0010.
  - A second valid branch presented at T+1 is ignored, so exactly one redirect occurs.
- Non-branch: valid with inst_id=4'b0000 for 10 cycles.
  - Required: busy, redirect and flush stay 0.
- Reset mid-flight: assert reset in EVAL for a taken beq.
  - Required: no redirect ever; all outputs 0 the cycle after reset; a new branch is accepted the cycle reset drops.
- With BRANCH_STATS_EN: run 3 branches, 2 of them taken.
  - Required: branch_count=3 and taken_count=2; both read 0 after reset.
